// File: rtl/bcd_serial_sub_ctrl_if.sv
// Host-side handshake and operand/result bundle for the digit-serial BCD subtract controller.
interface bcd_serial_sub_ctrl_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   diff;
  logic                  sign;
  logic                  invalid;

  modport master (
    output start, a, b,
    input  busy, done, diff, sign, invalid
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, sign, invalid
  );
endinterface

// File: rtl/bcd_serial_sub_ctrl.sv
// Multi-digit signed BCD subtraction A - B, one digit per cycle through a single
// digit subtractor, with a second pass converting a negative 10's-complement result to magnitude.
module bcd_serial_sub_ctrl #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_serial_sub_ctrl_if.slave  bus
);
  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, SUB, FIX, DONE} state_t;

  state_t         state, state_next;
  logic [W-1:0]   a_r, a_next, b_r, b_next, r_r, r_next;
  logic [W-1:0]   diff_r, diff_next;
  logic [IW-1:0]  idx, idx_next;
  logic           borrow, borrow_next;
  logic           sign_r, sign_next, inv_r, inv_next;

  logic [IW+1:0]  base;
  logic [3:0]     x, y, digit;
  logic [4:0]     t;
  logic           bout, last;

  function automatic logic has_non_bcd(input logic [W-1:0] v);
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Shared digit stage: SUB computes a_i - b_i - borrow, FIX computes 0 - r_i - borrow.
  always_comb begin
    base  = {idx, 2'b00};
    x     = (state == FIX) ? 4'd0 : a_r[base +: 4];
    y     = (state == FIX) ? r_r[base +: 4] : b_r[base +: 4];
    t     = {1'b0, x} - {1'b0, y} - {4'd0, borrow};
    bout  = t[4];
    digit = bout ? (t[3:0] + 4'd10) : t[3:0];
    last  = (idx == IW'(DIGITS - 1));
  end

  // Visible results are loaded on the edge entering DONE so they are valid alongside done.
  always_comb begin
    state_next  = state;
    a_next      = a_r;
    b_next      = b_r;
    r_next      = r_r;
    idx_next    = idx;
    borrow_next = borrow;
    diff_next   = diff_r;
    sign_next   = sign_r;
    inv_next    = inv_r;
    case (state)
      IDLE: begin
        if (bus.start) begin
          a_next      = bus.a;
          b_next      = bus.b;
          r_next      = '0;
          idx_next    = '0;
          borrow_next = 1'b0;
          if (has_non_bcd(bus.a) || has_non_bcd(bus.b)) begin
            state_next = DONE;
            diff_next  = '0;
            sign_next  = 1'b0;
            inv_next   = 1'b1;
          end else begin
            state_next = SUB;
          end
        end
      end
      SUB: begin
        r_next[base +: 4] = digit;
        borrow_next       = bout;
        idx_next          = idx + 1'b1;
        if (last) begin
          idx_next = '0;
          if (!bout) begin
            state_next = DONE;
            diff_next  = r_next;
            sign_next  = 1'b0;
            inv_next   = 1'b0;
          end else begin
            state_next  = FIX;
            borrow_next = 1'b0;
          end
        end
      end
      FIX: begin
        r_next[base +: 4] = digit;
        borrow_next       = bout;
        idx_next          = idx + 1'b1;
        if (last) begin
          idx_next   = '0;
          state_next = DONE;
          diff_next  = r_next;
          sign_next  = 1'b1;
          inv_next   = 1'b0;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      r_r    <= '0;
      idx    <= '0;
      borrow <= 1'b0;
      diff_r <= '0;
      sign_r <= 1'b0;
      inv_r  <= 1'b0;
    end else begin
      state  <= state_next;
      a_r    <= a_next;
      b_r    <= b_next;
      r_r    <= r_next;
      idx    <= idx_next;
      borrow <= borrow_next;
      diff_r <= diff_next;
      sign_r <= sign_next;
      inv_r  <= inv_next;
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.diff    = diff_r;
  assign bus.sign    = sign_r;
  assign bus.invalid = inv_r;
endmodule

// File: tb/tb_bcd_serial_sub_ctrl.sv
// Directed bench for bcd_serial_sub_ctrl with DIGITS = 4 and hand-computed results.
module tb_bcd_serial_sub_ctrl;
  localparam int unsigned DIGITS = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bcd_serial_sub_ctrl_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_sub_ctrl #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc;

  // Drives a one-cycle start; returns just after the accepting edge (cycle 1).
  task automatic issue(input logic [15:0] av, input logic [15:0] bv);
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cyc = 1;
  endtask

  task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                        output int lat, output logic [15:0] d, output logic s,
                        output logic inv, output logic [15:0] hd, output logic hs,
                        output logic busy_ok);
    issue(av, bv);
    lat = -1;
    busy_ok = 1'b1;
    hd = bus.diff;
    hs = bus.sign;
    d = bus.diff;
    s = bus.sign;
    inv = bus.invalid;
    for (int k = 0; k < 40; k++) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (cyc == 2) begin
        hd = bus.diff;
        hs = bus.sign;
      end
      if (bus.done === 1'b1) begin
        lat = cyc;
        d = bus.diff;
        s = bus.sign;
        inv = bus.invalid;
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    @(posedge clk);
    #1;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) busy_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.diff !== 16'h0000) begin failures++; $display("FAIL reset_diff got=%h exp=0000", bus.diff); end
    checks++; if (bus.sign !== 1'b0) begin failures++; $display("FAIL reset_sign got=%b exp=0", bus.sign); end
    checks++; if (bus.invalid !== 1'b0) begin failures++; $display("FAIL reset_invalid got=%b exp=0", bus.invalid); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_positive();
    int lat; logic [15:0] d, hd; logic s, inv, hs, bok;
    run_op(16'h0007, 16'h0004, lat, d, s, inv, hd, hs, bok);
    checks++; if (lat !== 5) begin failures++; $display("FAIL pos_latency got=%0d exp=5", lat); end
    checks++; if (d !== 16'h0003) begin failures++; $display("FAIL pos_diff got=%h exp=0003", d); end
    checks++; if (s !== 1'b0) begin failures++; $display("FAIL pos_sign got=%b exp=0", s); end
    checks++; if (inv !== 1'b0) begin failures++; $display("FAIL pos_invalid got=%b exp=0", inv); end
    checks++; if (bok !== 1'b1) begin failures++; $display("FAIL pos_busy_window got=%b exp=1", bok); end
  endtask

  task automatic test_negative();
    int lat; logic [15:0] d, hd; logic s, inv, hs, bok;
    run_op(16'h0004, 16'h0007, lat, d, s, inv, hd, hs, bok);
    checks++; if (lat !== 9) begin failures++; $display("FAIL neg_latency got=%0d exp=9", lat); end
    checks++; if (d !== 16'h0003) begin failures++; $display("FAIL neg_diff got=%h exp=0003", d); end
    checks++; if (s !== 1'b1) begin failures++; $display("FAIL neg_sign got=%b exp=1", s); end
    checks++; if (hd !== 16'h0003 || hs !== 1'b0) begin failures++; $display("FAIL neg_hold got=%h/%b exp=0003/0", hd, hs); end
    checks++; if (bok !== 1'b1) begin failures++; $display("FAIL neg_busy_window got=%b exp=1", bok); end
  endtask

  task automatic test_ripple();
    int lat; logic [15:0] d, hd; logic s, inv, hs, bok;
    run_op(16'h0003, 16'h0008, lat, d, s, inv, hd, hs, bok);
    checks++; if (d !== 16'h0005 || s !== 1'b1) begin failures++; $display("FAIL small_neg got=%h/%b exp=0005/1", d, s); end
    run_op(16'h1000, 16'h0001, lat, d, s, inv, hd, hs, bok);
    checks++; if (d !== 16'h0999 || s !== 1'b0) begin failures++; $display("FAIL ripple got=%h/%b exp=0999/0", d, s); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL ripple_latency got=%0d exp=5", lat); end
  endtask

  task automatic test_boundaries();
    int lat; logic [15:0] d, hd; logic s, inv, hs, bok;
    run_op(16'h9999, 16'h9999, lat, d, s, inv, hd, hs, bok);
    checks++; if (d !== 16'h0000 || s !== 1'b0) begin failures++; $display("FAIL equal got=%h/%b exp=0000/0", d, s); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL equal_latency got=%0d exp=5", lat); end
    run_op(16'h0000, 16'h9999, lat, d, s, inv, hd, hs, bok);
    checks++; if (d !== 16'h9999 || s !== 1'b1) begin failures++; $display("FAIL max_neg got=%h/%b exp=9999/1", d, s); end
    checks++; if (lat !== 9) begin failures++; $display("FAIL max_neg_latency got=%0d exp=9", lat); end
  endtask

  task automatic test_invalid();
    int lat; logic [15:0] d, hd; logic s, inv, hs, bok;
    run_op(16'h00A0, 16'h0001, lat, d, s, inv, hd, hs, bok);
    checks++; if (lat !== 1) begin failures++; $display("FAIL inv_latency got=%0d exp=1", lat); end
    checks++; if (inv !== 1'b1) begin failures++; $display("FAIL inv_flag got=%b exp=1", inv); end
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL inv_diff got=%h exp=0000", d); end
    checks++; if (s !== 1'b0) begin failures++; $display("FAIL inv_sign got=%b exp=0", s); end
  endtask

  task automatic test_start_ignored();
    int lat;
    issue(16'h0007, 16'h0004);
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (cyc == 2) begin
        bus.a = 16'h0004;
        bus.b = 16'h0007;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) begin
        lat = cyc;
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.start = 1'b0;
    checks++; if (lat !== 5) begin failures++; $display("FAIL ign_latency got=%0d exp=5", lat); end
    checks++; if (bus.diff !== 16'h0003 || bus.sign !== 1'b0) begin failures++; $display("FAIL ign_result got=%h/%b exp=0003/0", bus.diff, bus.sign); end
    checks++; if (bus.invalid !== 1'b0) begin failures++; $display("FAIL ign_invalid got=%b exp=0", bus.invalid); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_abort();
    int lat; logic [15:0] d, hd; logic s, inv, hs, bok; logic saw_done;
    issue(16'h0004, 16'h0007);
    @(posedge clk); #1; cyc++;
    @(posedge clk); #1; cyc++;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL abort_ctrl got=%b%b exp=00", bus.busy, bus.done); end
    checks++; if (bus.diff !== 16'h0000 || bus.sign !== 1'b0 || bus.invalid !== 1'b0) begin failures++; $display("FAIL abort_outputs got=%h/%b/%b exp=0000/0/0", bus.diff, bus.sign, bus.invalid); end
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%b exp=0", saw_done); end
    run_op(16'h0007, 16'h0004, lat, d, s, inv, hd, hs, bok);
    checks++; if (lat !== 5 || d !== 16'h0003 || s !== 1'b0) begin failures++; $display("FAIL abort_recover got=%0d/%h/%b exp=5/0003/0", lat, d, s); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [15:0] first_diff;
    issue(16'h0010, 16'h0001);
    lat = -1;
    first_diff = 16'hFFFF;
    for (int k = 0; k < 40; k++) begin
      if (bus.done === 1'b1) begin
        lat = cyc;
        first_diff = bus.diff;
        break;
      end
      @(posedge clk); #1; cyc++;
    end
    checks++; if (lat !== 5 || first_diff !== 16'h0009) begin failures++; $display("FAIL b2b_first got=%0d/%h exp=5/0009", lat, first_diff); end
    bus.a = 16'h0002;
    bus.b = 16'h0005;
    bus.start = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap got=%b exp=0", bus.busy); end
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", bus.busy); end
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (bus.done === 1'b1) begin
        lat = cyc;
        break;
      end
      @(posedge clk); #1; cyc++;
    end
    checks++; if (lat !== 9 || bus.diff !== 16'h0003 || bus.sign !== 1'b1) begin failures++; $display("FAIL b2b_second got=%0d/%h/%b exp=9/0003/1", lat, bus.diff, bus.sign); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_positive();
    test_negative();
    test_ripple();
    test_boundaries();
    test_invalid();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
